// File: rtl/sprite_mover_pkg.sv
// rtl/sprite_mover_pkg.sv - shared state, direction and colour definitions for the sprite mover
package sprite_mover_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_DRAW,
      ST_READY,
      ST_ERASE
   } state_t;

   typedef enum logic [1:0] {
      DIR_LEFT,
      DIR_RIGHT,
      DIR_UP,
      DIR_DOWN
   } dir_t;

   localparam int DEF_BG_COLOUR     = 0;
   localparam int DEF_TRANSP_COLOUR = 7;

endpackage

// File: rtl/sprite_mover_rect_scanner.sv
// rtl/sprite_mover_rect_scanner.sv - row-major raster walker over a rectangle at a given origin
module sprite_mover_rect_scanner #(
   parameter int X_W = 8,
   parameter int Y_W = 7,
   parameter int I_W = 7
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clear,
   input  logic           advance,
   input  logic [X_W-1:0] org_x,
   input  logic [Y_W-1:0] org_y,
   input  logic [X_W-1:0] last_col,
   input  logic [Y_W-1:0] last_row,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic [I_W-1:0] index,
   output logic           last
);

   logic [X_W-1:0] col;
   logic [Y_W-1:0] row;

   // index only addresses sprite-sized areas; it wraps harmlessly during a full-screen walk
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         col   <= '0;
         row   <= '0;
         index <= '0;
      end else if (advance) begin
         index <= index + 1'b1;
         if (col == last_col) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign x    = org_x + col;
   assign y    = org_y + row;
   assign last = (col == last_col) && (row == last_row);

endmodule

// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - sprite engine: screen clear, ROM sprite draw, clamped erase-then-redraw moves
module sprite_mover
   import sprite_mover_pkg::*;
#(
   parameter int SCREEN_W      = 160,
   parameter int SCREEN_H      = 120,
   parameter int X_W           = 8,
   parameter int Y_W           = 7,
   parameter int SPR_W         = 11,
   parameter int SPR_H         = 10,
   parameter int ADDR_W        = 7,
   parameter int X_INIT        = 73,
   parameter int Y_INIT        = 105,
   parameter int STEP          = 5,
   parameter int COL_W         = 3,
   parameter int BG_COLOUR     = DEF_BG_COLOUR,
   parameter int TRANSP_EN     = 0,
   parameter int TRANSP_COLOUR = DEF_TRANSP_COLOUR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              move_left,
   input  logic              move_right,
   input  logic              move_up,
   input  logic              move_down,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [COL_W-1:0]  rom_data,
   output logic [X_W-1:0]    x_out,
   output logic [Y_W-1:0]    y_out,
   output logic [COL_W-1:0]  colour_out,
   output logic              plot,
   output logic              busy,
   output logic              done,
   output logic              blocked,
   output logic [X_W-1:0]    pos_x,
   output logic [Y_W-1:0]    pos_y
);

   localparam logic [X_W-1:0] HOME_X   = X_W'(X_INIT);
   localparam logic [Y_W-1:0] HOME_Y   = Y_W'(Y_INIT);
   localparam logic [X_W:0]   STEP_X   = (X_W+1)'(STEP);
   localparam logic [Y_W:0]   STEP_Y   = (Y_W+1)'(STEP);
   localparam logic [X_W:0]   MAX_X    = (X_W+1)'(SCREEN_W - SPR_W);
   localparam logic [Y_W:0]   MAX_Y    = (Y_W+1)'(SCREEN_H - SPR_H);
   localparam logic [COL_W-1:0] BG_C   = COL_W'(BG_COLOUR);
   localparam logic [COL_W-1:0] TR_C   = COL_W'(TRANSP_COLOUR);

   state_t state, state_nxt;
   logic [X_W-1:0] tgt_x, tgt_x_nxt, pos_x_nxt, sc_x, px_x;
   logic [Y_W-1:0] tgt_y, tgt_y_nxt, pos_y_nxt, sc_y, px_y;
   logic [ADDR_W-1:0] sc_index;
   logic sc_clear, sc_adv, sc_last, sc_full;
   logic tail, tail_nxt, px_valid, px_nxt, px_bg, px_bg_nxt, done_nxt, blocked_nxt;
   logic dir_valid;
   dir_t dir;
   logic [X_W:0] pos_xw, right_sum, tx_w;
   logic [Y_W:0] pos_yw, down_sum, ty_w;

   assign sc_full = (state == ST_CLEAR);

   sprite_mover_rect_scanner #(.X_W(X_W), .Y_W(Y_W), .I_W(ADDR_W)) u_scan (
      .clk      (clk),
      .reset    (reset),
      .clear    (sc_clear),
      .advance  (sc_adv),
      .org_x    (sc_full ? '0 : pos_x),
      .org_y    (sc_full ? '0 : pos_y),
      .last_col (sc_full ? X_W'(SCREEN_W - 1) : X_W'(SPR_W - 1)),
      .last_row (sc_full ? Y_W'(SCREEN_H - 1) : Y_W'(SPR_H - 1)),
      .x        (sc_x),
      .y        (sc_y),
      .index    (sc_index),
      .last     (sc_last)
   );

   // Opposing pairs cancel each other before priority is applied
   always_comb begin
      dir_valid = 1'b1;
      dir       = DIR_LEFT;
      if (move_left && !move_right)      dir = DIR_LEFT;
      else if (move_right && !move_left) dir = DIR_RIGHT;
      else if (move_up && !move_down)    dir = DIR_UP;
      else if (move_down && !move_up)    dir = DIR_DOWN;
      else                               dir_valid = 1'b0;
   end

   assign pos_xw    = {1'b0, pos_x};
   assign pos_yw    = {1'b0, pos_y};
   assign right_sum = pos_xw + STEP_X;
   assign down_sum  = pos_yw + STEP_Y;

   always_comb begin
      tx_w = pos_xw;
      ty_w = pos_yw;
      case (dir)
         DIR_LEFT:  tx_w = (pos_xw < STEP_X) ? '0 : pos_xw - STEP_X;
         DIR_RIGHT: tx_w = (right_sum > MAX_X) ? MAX_X : right_sum;
         DIR_UP:    ty_w = (pos_yw < STEP_Y) ? '0 : pos_yw - STEP_Y;
         DIR_DOWN:  ty_w = (down_sum > MAX_Y) ? MAX_Y : down_sum;
         default:   tx_w = pos_xw;
      endcase
   end

   always_comb begin
      state_nxt   = state;
      sc_clear    = 1'b0;
      sc_adv      = 1'b0;
      px_nxt      = 1'b0;
      px_bg_nxt   = 1'b1;
      tail_nxt    = tail;
      done_nxt    = 1'b0;
      blocked_nxt = 1'b0;
      pos_x_nxt   = pos_x;
      pos_y_nxt   = pos_y;
      tgt_x_nxt   = tgt_x;
      tgt_y_nxt   = tgt_y;
      case (state)
         ST_IDLE: if (start) begin
            state_nxt = ST_CLEAR;
            sc_clear  = 1'b1;
            pos_x_nxt = HOME_X;
            pos_y_nxt = HOME_Y;
         end
         ST_CLEAR: begin
            sc_adv = 1'b1;
            px_nxt = 1'b1;
            if (sc_last) begin
               state_nxt = ST_DRAW;
               sc_clear  = 1'b1;
            end
         end
         // One extra tail cycle lets the last ROM pixel leave the pipeline before done
         ST_DRAW: if (!tail) begin
            sc_adv    = 1'b1;
            px_nxt    = 1'b1;
            px_bg_nxt = 1'b0;
            tail_nxt  = sc_last;
         end else begin
            tail_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = ST_READY;
         end
         ST_READY: if (dir_valid) begin
            if (tx_w == pos_xw && ty_w == pos_yw) begin
               blocked_nxt = 1'b1;
            end else begin
               tgt_x_nxt = tx_w[X_W-1:0];
               tgt_y_nxt = ty_w[Y_W-1:0];
               state_nxt = ST_ERASE;
               sc_clear  = 1'b1;
            end
         end
         ST_ERASE: begin
            sc_adv = 1'b1;
            px_nxt = 1'b1;
            if (sc_last) begin
               state_nxt = ST_DRAW;
               sc_clear  = 1'b1;
               pos_x_nxt = tgt_x;
               pos_y_nxt = tgt_y;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ST_IDLE;
         tail     <= 1'b0;
         px_valid <= 1'b0;
         px_bg    <= 1'b0;
         px_x     <= '0;
         px_y     <= '0;
         done     <= 1'b0;
         blocked  <= 1'b0;
         pos_x    <= HOME_X;
         pos_y    <= HOME_Y;
         tgt_x    <= HOME_X;
         tgt_y    <= HOME_Y;
      end else begin
         state    <= state_nxt;
         tail     <= tail_nxt;
         px_valid <= px_nxt;
         px_bg    <= px_bg_nxt;
         px_x     <= sc_x;
         px_y     <= sc_y;
         done     <= done_nxt;
         blocked  <= blocked_nxt;
         pos_x    <= pos_x_nxt;
         pos_y    <= pos_y_nxt;
         tgt_x    <= tgt_x_nxt;
         tgt_y    <= tgt_y_nxt;
      end
   end

   assign rom_addr   = (state == ST_DRAW && !tail) ? sc_index : '0;
   assign x_out      = px_x;
   assign y_out      = px_y;
   assign colour_out = px_valid ? (px_bg ? BG_C : rom_data) : '0;
   assign plot       = px_valid && (px_bg || !(TRANSP_EN != 0 && rom_data == TR_C));
   assign busy       = (state != ST_IDLE) && (state != ST_READY);

endmodule

// File: tb/tb_sprite_mover.sv
// tb/tb_sprite_mover.sv - scoreboard bench for sprite_mover with a transparent-pixel sprite ROM
module tb_sprite_mover;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   logic       clk = 1'b0;
   logic       reset, start, move_left, move_right, move_up, move_down;
   logic [6:0] rom_addr;
   logic [2:0] rom_data = 3'd0;
   logic [7:0] x_out, pos_x;
   logic [6:0] y_out, pos_y;
   logic [2:0] colour_out;
   logic       plot, busy, done, blocked;

   pix_t exp_q[$];
   int   checks = 0, errors = 0, done_cnt = 0, blk_cnt = 0;
   int   cur_x = 73, cur_y = 105;

   sprite_mover #(.TRANSP_EN(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .move_left  (move_left),
      .move_right (move_right),
      .move_up    (move_up),
      .move_down  (move_down),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .x_out      (x_out),
      .y_out      (y_out),
      .colour_out (colour_out),
      .plot       (plot),
      .busy       (busy),
      .done       (done),
      .blocked    (blocked),
      .pos_x      (pos_x),
      .pos_y      (pos_y)
   );

   always #5 clk = ~clk;

   // Address 0 holds the transparent colour; every other pixel is 1..6
   function automatic logic [2:0] rom_fn(input int a);
      if (a == 0) return 3'd7;
      return 3'((a % 6) + 1);
   endfunction

   always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push_rect(input int x0, input int y0, input int w, input int h, input bit bg);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            if (bg) exp_q.push_back('{8'(x0 + c), 7'(y0 + r), 3'd0});
            else if (rom_fn(r * 11 + c) != 3'd7)
               exp_q.push_back('{8'(x0 + c), 7'(y0 + r), rom_fn(r * 11 + c)});
         end
   endtask

   initial begin
      pix_t p;
      forever begin
         @(negedge clk);
         if (done && blocked) begin
            checks++; errors++;
            $display("FAIL done_and_blocked actual=1 required=0");
         end
         if (done) done_cnt++;
         if (blocked) blk_cnt++;
         if (plot) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_plot actual=(%0d,%0d,%0d) required=none", x_out, y_out, colour_out);
            end else begin
               p = exp_q.pop_front();
               if ({x_out, y_out, colour_out} !== p) begin
                  errors++;
                  $display("FAIL pixel actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                           x_out, y_out, colour_out, p.x, p.y, p.c);
               end
            end
         end
      end
   end

   task automatic wait_done(input int budget);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(posedge clk); #2;
         n++;
      end
      check("done_seen", done_cnt, d0 + 1);
   endtask

   task automatic pulse(input logic [3:0] cmd);
      @(posedge clk); #1;
      {move_left, move_right, move_up, move_down} = cmd;
      @(posedge clk); #1;
      {move_left, move_right, move_up, move_down} = 4'b0000;
   endtask

   task automatic do_move(input logic [3:0] cmd, input int nx, input int ny);
      push_rect(cur_x, cur_y, 11, 10, 1'b1);
      push_rect(nx, ny, 11, 10, 1'b0);
      pulse(cmd);
      wait_done(400);
      check("pos_x", pos_x, nx);
      check("pos_y", pos_y, ny);
      check("queue_empty", exp_q.size(), 0);
      cur_x = nx;
      cur_y = ny;
   endtask

   task automatic do_blocked(input logic [3:0] cmd);
      int b0 = blk_cnt;
      pulse(cmd);
      repeat (4) @(posedge clk);
      #2;
      check("blocked_pulse", blk_cnt, b0 + 1);
      check("blocked_idle", busy, 0);
      check("blocked_pos_x", pos_x, cur_x);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; start = 1'b0;
      {move_left, move_right, move_up, move_down} = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_plot", plot, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_x_out", x_out, 0);
      check("rst_colour", colour_out, 0);
      check("rst_pos_x", pos_x, 73);
      check("rst_pos_y", pos_y, 105);
      reset = 1'b1;

      push_rect(0, 0, 160, 120, 1'b1);
      push_rect(73, 105, 11, 10, 1'b0);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(20000);
      check("init_done_once", done_cnt, 1);
      check("init_queue_empty", exp_q.size(), 0);
      check("init_ready", busy, 0);

      do_move(4'b1000, 68, 105);
      for (int i = 1; i <= 13; i++) do_move(4'b1000, 68 - 5 * i, 105);
      do_move(4'b1000, 0, 105);
      do_blocked(4'b1000);
      for (int i = 1; i <= 29; i++) do_move(4'b0100, 5 * i, 105);
      do_move(4'b0100, 149, 105);
      do_blocked(4'b0100);
      do_move(4'b0001, 149, 110);
      do_blocked(4'b0001);
      do_move(4'b0010, 149, 105);

      pulse(4'b1100);
      repeat (4) @(posedge clk);
      #2;
      check("opposed_idle", busy, 0);
      check("opposed_pos_x", pos_x, 149);

      push_rect(149, 105, 11, 10, 1'b1);
      push_rect(149, 100, 11, 10, 1'b0);
      pulse(4'b0010);
      repeat (148) @(posedge clk);
      #1 move_left = 1'b1;
      repeat (30) @(posedge clk);
      #1 move_left = 1'b0;
      wait_done(400);
      repeat (5) @(posedge clk);
      #2;
      check("busy_cmd_ignored_x", pos_x, 149);
      check("busy_cmd_ignored_y", pos_y, 100);
      check("busy_cmd_idle", busy, 0);
      cur_x = 149; cur_y = 100;

      push_rect(149, 100, 11, 10, 1'b1);
      pulse(4'b1000);
      repeat (30) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      exp_q.delete();
      check("abort_plot", plot, 0);
      check("abort_busy", busy, 0);
      check("abort_pos_x", pos_x, 73);
      check("abort_pos_y", pos_y, 105);
      repeat (5) @(posedge clk);
      #2;
      check("abort_stays_idle", busy, 0);

      push_rect(0, 0, 160, 120, 1'b1);
      push_rect(73, 105, 11, 10, 1'b0);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(20000);
      check("restart_queue_empty", exp_q.size(), 0);
      check("restart_pos_x", pos_x, 73);
      check("restart_pos_y", pos_y, 105);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
